// File: rtl/riscv_dift_check_unit_if.sv
// -----------------------------------------------------------------------------
// riscv_dift_check_unit_if
// Bundles the EX-stage tag inputs, the trap handshake and the sticky violation
// record of the DIFT check unit into a single interface.
//   master : pipeline/controller side (drives tags, policy, ack, clear)
//   slave  : check unit side (drives trap request, stall, violation record)
// Signals:
//   enable_i, tcr_i, valid_i, class_i, is_store_i, tag_*_i, pc_i,
//   trap_ack_i, clear_i                      -> towards the check unit
//   trap_req_o, stall_o, viol_valid_o, viol_pc_o, viol_cause_o,
//   viol_cnt_o                               -> from the check unit
// -----------------------------------------------------------------------------
interface riscv_dift_check_unit_if #(
   parameter int TCR_WIDTH  = 23,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   logic                  enable_i;
   logic [TCR_WIDTH-1:0]  tcr_i;
   logic                  valid_i;
   logic [2:0]            class_i;
   logic                  is_store_i;
   logic                  tag_rs1_i;
   logic                  tag_rs2_i;
   logic                  tag_rd_i;
   logic                  tag_pc_i;
   logic                  tag_instr_i;
   logic [ADDR_WIDTH-1:0] pc_i;
   logic                  trap_ack_i;
   logic                  clear_i;
   logic                  trap_req_o;
   logic                  stall_o;
   logic                  viol_valid_o;
   logic [ADDR_WIDTH-1:0] viol_pc_o;
   logic [4:0]            viol_cause_o;
   logic [CNT_WIDTH-1:0]  viol_cnt_o;

   modport master (
      output enable_i, tcr_i, valid_i, class_i, is_store_i,
             tag_rs1_i, tag_rs2_i, tag_rd_i, tag_pc_i, tag_instr_i,
             pc_i, trap_ack_i, clear_i,
      input  trap_req_o, stall_o, viol_valid_o, viol_pc_o,
             viol_cause_o, viol_cnt_o
   );

   modport slave (
      input  enable_i, tcr_i, valid_i, class_i, is_store_i,
             tag_rs1_i, tag_rs2_i, tag_rd_i, tag_pc_i, tag_instr_i,
             pc_i, trap_ack_i, clear_i,
      output trap_req_o, stall_o, viol_valid_o, viol_pc_o,
             viol_cause_o, viol_cnt_o
   );
endinterface

// File: rtl/riscv_dift_check_unit.sv
// -----------------------------------------------------------------------------
// riscv_dift_check_unit
// DIFT tag-check stage in EX. Builds a per-class check vector from the operand,
// PC and instruction tags, masks it with the Tag Check Register and, on a hit,
// raises a security trap request one cycle later and holds EX until the
// controller acknowledges. A sticky record keeps the PC and cause of the first
// unserviced violation plus a saturating violation count.
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active-high
//   dift : riscv_dift_check_unit_if.slave (tags, policy, trap handshake,
//          clear strobe, violation record outputs)
// -----------------------------------------------------------------------------
module riscv_dift_check_unit #(
   parameter int TCR_WIDTH  = 23,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   riscv_dift_check_unit_if.slave dift
);

   localparam logic [2:0] CLS_INT    = 3'd0;
   localparam logic [2:0] CLS_BRANCH = 3'd1;
   localparam logic [2:0] CLS_JUMP   = 3'd2;
   localparam logic [2:0] CLS_SHIFT  = 3'd3;
   localparam logic [2:0] CLS_CMP    = 3'd4;
   localparam logic [2:0] CLS_LOGIC  = 3'd5;
   localparam logic [2:0] CLS_LDST   = 3'd6;
   localparam logic [2:0] CLS_NONE   = 3'd7;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_t;

   state_t                state_r;
   state_t                state_next_s;
   logic [TCR_WIDTH-1:0]  chk_s;
   logic [TCR_WIDTH-1:0]  hit_s;
   logic                  viol_s;
   logic [4:0]            cause_s;
   logic                  viol_valid_r;
   logic [ADDR_WIDTH-1:0] viol_pc_r;
   logic [4:0]            viol_cause_r;
   logic [CNT_WIDTH-1:0]  viol_cnt_r;

   // Index of the lowest set bit; the vector is known non-zero when used.
   function automatic logic [4:0] lowest_set(input logic [TCR_WIDTH-1:0] v);
      logic [4:0] idx;
      idx = 5'd0;
      for (int i = TCR_WIDTH - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = 5'(i);
         end
      end
      return idx;
   endfunction

   // Check vector: one bit per (class, operand) pair, only for a new
   // instruction accepted while idle. A stalled EX slot produces no checks.
   always_comb begin
      chk_s = '0;
      if (dift.valid_i && dift.enable_i && (state_r == ST_IDLE)) begin
         case (dift.class_i)
            CLS_INT: begin
               chk_s[0] = dift.tag_rs1_i;
               chk_s[1] = dift.tag_rs2_i;
               chk_s[2] = dift.tag_rd_i;
            end
            CLS_BRANCH: begin
               chk_s[3] = dift.tag_rs1_i;
               chk_s[4] = dift.tag_rs2_i;
            end
            CLS_JUMP: begin
               chk_s[5] = dift.tag_rs1_i;
               chk_s[6] = dift.tag_rs2_i;
               chk_s[7] = dift.tag_rd_i;
            end
            CLS_SHIFT: begin
               chk_s[8]  = dift.tag_rs1_i;
               chk_s[9]  = dift.tag_rs2_i;
               chk_s[10] = dift.tag_rd_i;
            end
            CLS_CMP: begin
               chk_s[11] = dift.tag_rs1_i;
               chk_s[12] = dift.tag_rs2_i;
               chk_s[13] = dift.tag_rd_i;
            end
            CLS_LOGIC: begin
               chk_s[14] = dift.tag_rs1_i;
               chk_s[15] = dift.tag_rs2_i;
               chk_s[16] = dift.tag_rd_i;
            end
            CLS_LDST: begin
               // Bit 17 is the data tag for both directions: store data comes
               // from rs2, load data is the memory tag propagated to rd.
               if (dift.is_store_i) begin
                  chk_s[17] = dift.tag_rs2_i;
                  chk_s[20] = dift.tag_rs1_i;
               end else begin
                  chk_s[17] = dift.tag_rd_i;
                  chk_s[18] = dift.tag_rs1_i;
               end
            end
            default: begin
               chk_s = '0;
            end
         endcase
         if (dift.class_i != CLS_NONE) begin
            chk_s[21] = dift.tag_pc_i;
            chk_s[22] = dift.tag_instr_i;
         end else begin
            chk_s[21] = 1'b0;
            chk_s[22] = 1'b0;
         end
      end else begin
         chk_s = '0;
      end
   end

   assign hit_s   = chk_s & dift.tcr_i;
   assign viol_s  = |hit_s;
   assign cause_s = lowest_set(hit_s);

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next state: a hit moves to REQ, an ack returns to IDLE.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (viol_s) begin
               state_next_s = ST_REQ;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (dift.trap_ack_i) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_REQ;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Sticky violation record. A capture coinciding with clear_i restarts the
   // record with the new violation, so the count starts again at one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         viol_valid_r <= 1'b0;
         viol_pc_r    <= '0;
         viol_cause_r <= 5'd0;
         viol_cnt_r   <= '0;
      end else if (viol_s) begin
         if (!viol_valid_r || dift.clear_i) begin
            viol_valid_r <= 1'b1;
            viol_pc_r    <= dift.pc_i;
            viol_cause_r <= cause_s;
         end
         if (dift.clear_i) begin
            viol_cnt_r <= CNT_WIDTH'(1);
         end else if (viol_cnt_r != {CNT_WIDTH{1'b1}}) begin
            viol_cnt_r <= viol_cnt_r + CNT_WIDTH'(1);
         end
      end else if (dift.clear_i) begin
         viol_valid_r <= 1'b0;
         viol_pc_r    <= '0;
         viol_cause_r <= 5'd0;
         viol_cnt_r   <= '0;
      end
   end

   assign dift.trap_req_o   = (state_r == ST_REQ);
   assign dift.stall_o      = (state_r == ST_REQ);
   assign dift.viol_valid_o = viol_valid_r;
   assign dift.viol_pc_o    = viol_pc_r;
   assign dift.viol_cause_o = viol_cause_r;
   assign dift.viol_cnt_o   = viol_cnt_r;

endmodule

// File: tb/tb_riscv_dift_check_unit.sv
// -----------------------------------------------------------------------------
// tb_riscv_dift_check_unit
// Drives two instances (16-bit and 2-bit violation counters) from the same
// stimulus. A behavioural model derives the trap/record state from the tag
// rules; a compare process checks both instances every cycle, and directed
// scenarios pin the model with hand-computed values.
// -----------------------------------------------------------------------------
module tb_riscv_dift_check_unit;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   riscv_dift_check_unit_if #(.TCR_WIDTH(23), .ADDR_WIDTH(32), .CNT_WIDTH(16)) bus ();
   riscv_dift_check_unit_if #(.TCR_WIDTH(23), .ADDR_WIDTH(32), .CNT_WIDTH(2))  bus2 ();

   riscv_dift_check_unit #(.TCR_WIDTH(23), .ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
      .clk  (clk),
      .rst  (rst),
      .dift (bus.slave)
   );

   riscv_dift_check_unit #(.TCR_WIDTH(23), .ADDR_WIDTH(32), .CNT_WIDTH(2)) dut2 (
      .clk  (clk),
      .rst  (rst),
      .dift (bus2.slave)
   );

   assign bus2.enable_i    = bus.enable_i;
   assign bus2.tcr_i       = bus.tcr_i;
   assign bus2.valid_i     = bus.valid_i;
   assign bus2.class_i     = bus.class_i;
   assign bus2.is_store_i  = bus.is_store_i;
   assign bus2.tag_rs1_i   = bus.tag_rs1_i;
   assign bus2.tag_rs2_i   = bus.tag_rs2_i;
   assign bus2.tag_rd_i    = bus.tag_rd_i;
   assign bus2.tag_pc_i    = bus.tag_pc_i;
   assign bus2.tag_instr_i = bus.tag_instr_i;
   assign bus2.pc_i        = bus.pc_i;
   assign bus2.trap_ack_i  = bus.trap_ack_i;
   assign bus2.clear_i     = bus.clear_i;

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic        m_pend  = 1'b0;
   logic        m_vv    = 1'b0;
   logic [31:0] m_pc    = 32'd0;
   int          m_cause = 0;
   int          m_cnt   = 0;
   int          m_cnt2  = 0;
   logic        m_viol;
   int          m_cz;

   // Is TCR bit b exercised by a tainted operand of this instruction?
   // t = {instr, pc, rd, rs2, rs1}
   function automatic bit m_hit(int b, logic [2:0] c, logic st, logic [4:0] t);
      int base;
      int n;
      if (c == 3'd7) return 1'b0;
      if (b == 21) return t[3];
      if (b == 22) return t[4];
      if (c == 3'd6) begin
         if (st) return (b == 17 && t[1]) || (b == 20 && t[0]);
         return (b == 17 && t[2]) || (b == 18 && t[0]);
      end
      base = (c == 3'd0) ? 0 : (c == 3'd1) ? 3 : 5 + 3 * (int'(c) - 2);
      n    = (c == 3'd1) ? 2 : 3;
      if (b >= base && b < base + n) return t[b - base];
      return 1'b0;
   endfunction

   always_comb begin
      m_viol = 1'b0;
      m_cz   = 0;
      for (int b = 22; b >= 0; b--) begin
         if (bus.tcr_i[b] && m_hit(b, bus.class_i, bus.is_store_i,
               {bus.tag_instr_i, bus.tag_pc_i, bus.tag_rd_i, bus.tag_rs2_i, bus.tag_rs1_i})) begin
            m_viol = 1'b1;
            m_cz   = b;
         end
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pend <= 1'b0; m_vv <= 1'b0; m_pc <= 32'd0;
         m_cause <= 0; m_cnt <= 0; m_cnt2 <= 0;
      end else if (!m_pend && bus.valid_i && bus.enable_i && m_viol) begin
         m_pend <= 1'b1;
         if (!m_vv || bus.clear_i) begin
            m_vv <= 1'b1; m_pc <= bus.pc_i; m_cause <= m_cz;
         end
         m_cnt  <= bus.clear_i ? 1 : ((m_cnt  < 65535) ? m_cnt + 1  : 65535);
         m_cnt2 <= bus.clear_i ? 1 : ((m_cnt2 < 3)     ? m_cnt2 + 1 : 3);
      end else begin
         if (m_pend && bus.trap_ack_i) m_pend <= 1'b0;
         if (bus.clear_i) begin
            m_vv <= 1'b0; m_pc <= 32'd0; m_cause <= 0; m_cnt <= 0; m_cnt2 <= 0;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: both instances against the model every cycle.
   always @(negedge clk) begin
      chk("trap_req",   64'(bus.trap_req_o),    64'(m_pend));
      chk("stall",      64'(bus.stall_o),       64'(m_pend));
      chk("viol_valid", 64'(bus.viol_valid_o),  64'(m_vv));
      chk("viol_pc",    64'(bus.viol_pc_o),     64'(m_pc));
      chk("viol_cause", 64'(bus.viol_cause_o),  64'(m_cause));
      chk("viol_cnt",   64'(bus.viol_cnt_o),    64'(m_cnt));
      chk("trap_req2",  64'(bus2.trap_req_o),   64'(m_pend));
      chk("viol_cnt2",  64'(bus2.viol_cnt_o),   64'(m_cnt2));
   end

   // Apply one cycle of inputs and return just after the following negedge.
   task automatic go(input logic v, input logic [2:0] c, input logic st, input logic [4:0] t,
                     input logic [31:0] p, input logic ack, input logic clr);
      bus.valid_i = v; bus.class_i = c; bus.is_store_i = st;
      {bus.tag_instr_i, bus.tag_pc_i, bus.tag_rd_i, bus.tag_rs2_i, bus.tag_rs1_i} = t;
      bus.pc_i = p; bus.trap_ack_i = ack; bus.clear_i = clr;
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      go(1'b0, 3'd7, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
   endtask

   initial begin
      bus.enable_i = 1'b1;
      bus.tcr_i    = 23'd0;
      bus.valid_i  = 1'b0; bus.class_i = 3'd7; bus.is_store_i = 1'b0;
      {bus.tag_instr_i, bus.tag_pc_i, bus.tag_rd_i, bus.tag_rs2_i, bus.tag_rs1_i} = 5'd0;
      bus.pc_i = 32'd0; bus.trap_ack_i = 1'b0; bus.clear_i = 1'b0;
      #1 rst = 1'b1;
      @(negedge clk); #1;
      chk("rst_trap", 64'(bus.trap_req_o), 64'd0);
      chk("rst_cnt",  64'(bus.viol_cnt_o), 64'd0);
      rst = 1'b0;
      idle();

      // INT rs1 violation.
      bus.tcr_i = 23'h1;
      go(1'b1, 3'd0, 1'b0, 5'b00001, 32'h100, 1'b0, 1'b0);
      chk("int_trap",  64'(bus.trap_req_o),   64'd1);
      chk("int_stall", 64'(bus.stall_o),      64'd1);
      chk("int_cause", 64'(bus.viol_cause_o), 64'd0);
      chk("int_pc",    64'(bus.viol_pc_o),    64'h100);
      chk("int_cnt",   64'(bus.viol_cnt_o),   64'd1);
      go(1'b0, 3'd7, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      chk("ack_drop", 64'(bus.trap_req_o), 64'd0);
      go(1'b0, 3'd7, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

      // NONE class never checks.
      bus.tcr_i = 23'h7FFFFF;
      go(1'b1, 3'd7, 1'b0, 5'b11111, 32'h300, 1'b0, 1'b0);
      chk("none_trap", 64'(bus.trap_req_o), 64'd0);
      chk("none_cnt",  64'(bus.viol_cnt_o), 64'd0);

      // Store address tag -> bit 20; load does not use bit 20.
      bus.tcr_i = 23'h1 << 20;
      go(1'b1, 3'd6, 1'b1, 5'b00001, 32'h400, 1'b0, 1'b0);
      chk("st_trap",  64'(bus.trap_req_o),   64'd1);
      chk("st_cause", 64'(bus.viol_cause_o), 64'd20);
      go(1'b0, 3'd7, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      go(1'b0, 3'd7, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      go(1'b1, 3'd6, 1'b0, 5'b00001, 32'h404, 1'b0, 1'b0);
      chk("ld_trap", 64'(bus.trap_req_o), 64'd0);

      // Two violations: record keeps the first PC, count is 2; then clear.
      bus.tcr_i = 23'h1;
      go(1'b1, 3'd0, 1'b0, 5'b00001, 32'h100, 1'b0, 1'b0);
      go(1'b0, 3'd7, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      go(1'b1, 3'd0, 1'b0, 5'b00001, 32'h200, 1'b0, 1'b0);
      go(1'b0, 3'd7, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      chk("two_pc",  64'(bus.viol_pc_o),  64'h100);
      chk("two_cnt", 64'(bus.viol_cnt_o), 64'd2);
      go(1'b0, 3'd7, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      chk("clr_valid", 64'(bus.viol_valid_o), 64'd0);
      chk("clr_pc",    64'(bus.viol_pc_o),    64'd0);
      chk("clr_cnt",   64'(bus.viol_cnt_o),   64'd0);

      // Violating valid during REQ with same-cycle ack is ignored.
      go(1'b1, 3'd0, 1'b0, 5'b00001, 32'h500, 1'b0, 1'b0);
      go(1'b1, 3'd0, 1'b0, 5'b00001, 32'h600, 1'b1, 1'b0);
      chk("ackwin_trap", 64'(bus.trap_req_o), 64'd0);
      chk("ackwin_cnt",  64'(bus.viol_cnt_o), 64'd1);
      chk("ackwin_pc",   64'(bus.viol_pc_o),  64'h500);
      idle();
      chk("ackwin_cnt2", 64'(bus.viol_cnt_o), 64'd1);
      go(1'b0, 3'd7, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

      // Saturation of the 2-bit counter.
      for (int i = 0; i < 4; i++) begin
         go(1'b1, 3'd0, 1'b0, 5'b00001, 32'h700 + 32'(i), 1'b0, 1'b0);
         go(1'b0, 3'd7, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      end
      chk("sat_cnt2", 64'(bus2.viol_cnt_o), 64'd3);
      chk("sat_cnt",  64'(bus.viol_cnt_o),  64'd4);

      // Async reset in the middle of REQ.
      go(1'b1, 3'd0, 1'b0, 5'b00001, 32'h800, 1'b0, 1'b0);
      chk("pre_rst_trap", 64'(bus.trap_req_o), 64'd1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_trap",  64'(bus.trap_req_o),   64'd0);
      chk("rst_mid_stall", 64'(bus.stall_o),      64'd0);
      chk("rst_mid_valid", 64'(bus.viol_valid_o), 64'd0);
      chk("rst_mid_cnt",   64'(bus.viol_cnt_o),   64'd0);
      @(negedge clk); #1;
      rst = 1'b0;
      idle();

      // Randomised traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         logic [22:0] tcr;
         tcr = 23'h1 << $urandom_range(0, 22);
         if ($urandom_range(0, 3) == 0) tcr = tcr | 23'($urandom);
         bus.tcr_i    = tcr;
         bus.enable_i = ($urandom_range(0, 9) != 0);
         go(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 1'($urandom),
            5'($urandom), $urandom, ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 31) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
